// File: rtl/tnn_if.sv
// Sample/prediction bus for the ternary neural-network classifier.
//   in_valid   : features valid this cycle (master -> slave)
//   features   : packed unsigned features, feature f at [f*FEAT_BITS +: FEAT_BITS]
//   out_valid  : prediction valid (slave -> master)
//   prediction : predicted class index
interface tnn_if #(
  parameter int unsigned FEAT_CNT  = 11,
  parameter int unsigned FEAT_BITS = 3,
  parameter int unsigned CLASS_CNT = 7
);
  localparam int unsigned PredW = $clog2(CLASS_CNT);

  logic                          in_valid;
  logic [FEAT_CNT*FEAT_BITS-1:0] features;
  logic                          out_valid;
  logic [PredW-1:0]              prediction;

  modport master (
    output in_valid,
    output features,
    input  out_valid,
    input  prediction
  );

  modport slave (
    input  in_valid,
    input  features,
    output out_valid,
    output prediction
  );
endinterface

// File: rtl/tnn_top.sv
// Pipelined ternary neural-network classifier, one sample per clock, three register stages.
//   Stage 1: register features/in_valid.
//   Stage 2: ternary-weighted hidden neurons with signed thresholds, register hid/valid.
//   Stage 3: ternary-weighted class scores, argmax (lowest index wins ties), register result.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous reset, active low
//   bus   : tnn_if slave modport (in_valid, features in; out_valid, prediction out)
// Weight encoding: 2'b01 = +1, 2'b11 = -1, 2'b00/2'b10 = 0.
module tnn_top #(
  parameter int unsigned FEAT_CNT   = 11,
  parameter int unsigned FEAT_BITS  = 3,
  parameter int unsigned HIDDEN_CNT = 10,
  parameter int unsigned CLASS_CNT  = 7,
  parameter logic [HIDDEN_CNT*FEAT_CNT*2-1:0] W1 = '0,
  parameter logic [HIDDEN_CNT*(FEAT_BITS+$clog2(FEAT_CNT+1)+1)-1:0] THR = '0,
  parameter logic [CLASS_CNT*HIDDEN_CNT*2-1:0] W2 = '0
) (
  input  logic   clk,
  input  logic   rst_n,
  tnn_if.slave   bus
);
  localparam int unsigned ACC_W    = FEAT_BITS + $clog2(FEAT_CNT + 1) + 1;
  localparam int unsigned SUM_BITS = $clog2(HIDDEN_CNT + 1);
  localparam int unsigned SCORE_W  = SUM_BITS + 1;
  localparam int unsigned PRED_W   = $clog2(CLASS_CNT);

  logic [FEAT_CNT*FEAT_BITS-1:0] feat_q, feat_d;
  logic                          v1_q, v1_d;
  logic [HIDDEN_CNT-1:0]         hid_q, hid_d;
  logic                          v2_q, v2_d;
  logic [PRED_W-1:0]             pred_q, pred_d;
  logic                          out_valid_q, out_valid_d;

  // Stage 1
  always_comb begin
    feat_d = bus.features;
    v1_d   = bus.in_valid;
  end

  // Stage 2: hidden layer. Features are zero-extended so the signed sum cannot overflow.
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] fval;
  logic signed [ACC_W-1:0] thr;

  always_comb begin
    hid_d = '0;
    acc   = '0;
    fval  = '0;
    thr   = '0;
    for (int h = 0; h < HIDDEN_CNT; h++) begin
      acc = '0;
      for (int f = 0; f < FEAT_CNT; f++) begin
        fval = signed'({{(ACC_W-FEAT_BITS){1'b0}}, feat_q[f*FEAT_BITS +: FEAT_BITS]});
        unique case (W1[(h*FEAT_CNT+f)*2 +: 2])
          2'b01:   acc = acc + fval;
          2'b11:   acc = acc - fval;
          default: acc = acc;
        endcase
      end
      thr      = signed'(THR[h*ACC_W +: ACC_W]);
      hid_d[h] = (acc >= thr);
    end
    v2_d = v1_q;
  end

  // Stage 3: class scores and argmax; strict '>' keeps the lowest index on ties.
  logic signed [SCORE_W-1:0] score;
  logic signed [SCORE_W-1:0] best;

  always_comb begin
    score  = '0;
    best   = '0;
    pred_d = '0;
    for (int c = 0; c < CLASS_CNT; c++) begin
      score = '0;
      for (int h = 0; h < HIDDEN_CNT; h++) begin
        if (hid_q[h]) begin
          unique case (W2[(c*HIDDEN_CNT+h)*2 +: 2])
            2'b01:   score = score + SCORE_W'(1);
            2'b11:   score = score - SCORE_W'(1);
            default: score = score;
          endcase
        end
      end
      if (c == 0 || score > best) begin
        best   = score;
        pred_d = PRED_W'(c);
      end
    end
    out_valid_d = v2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      feat_q      <= '0;
      v1_q        <= 1'b0;
      hid_q       <= '0;
      v2_q        <= 1'b0;
      pred_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      feat_q      <= feat_d;
      v1_q        <= v1_d;
      hid_q       <= hid_d;
      v2_q        <= v2_d;
      pred_q      <= pred_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.prediction = pred_q;
endmodule

// File: tb/tb_tnn_top.sv
// Bench for tnn_top in the small configuration:
//   h0 = f0 - f1 >= 0, h1 = f1 >= 4; class0 = +h0, class1 = +h1.
// The driver pushes hand-computed predictions and due cycles into a queue; a
// monitor pops and compares whenever out_valid is seen.
module tb_tnn_top;
  localparam int unsigned FC = 2;
  localparam int unsigned FB = 3;
  localparam int unsigned HC = 2;
  localparam int unsigned CC = 2;
  // (h,f) at [(h*2+f)*2]: (0,0)=+1, (0,1)=-1, (1,0)=0, (1,1)=+1
  localparam logic [7:0]  W1V  = 8'b01_00_11_01;
  // ACC_W = 6: THR h0 = 0, THR h1 = 4
  localparam logic [11:0] THRV = {6'd4, 6'd0};
  // (c,h) at [(c*2+h)*2]: (0,0)=+1, (1,1)=+1
  localparam logic [7:0]  W2V  = 8'b01_00_00_01;

  typedef struct {
    logic pred;
    int   due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cycle = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  tnn_if #(.FEAT_CNT(FC), .FEAT_BITS(FB), .CLASS_CNT(CC)) bus ();

  tnn_top #(
    .FEAT_CNT(FC), .FEAT_BITS(FB), .HIDDEN_CNT(HC), .CLASS_CNT(CC),
    .W1(W1V), .THR(THRV), .W2(W2V)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic send(input logic [2:0] f0, input logic [2:0] f1, input logic exp);
    exp_t e;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.features = {f1, f0};
    e.pred = exp;
    e.due  = cycle + 3;
    sb.push_back(e);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.features = 6'($urandom);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          e = sb.pop_front();
          check("prediction", int'(bus.prediction), int'(e.pred));
          check("latency_cycle", cycle, e.due);
        end
      end
    end
  end

  initial begin
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.features = 6'h3f;
    #12;
    check("reset_out_valid", int'(bus.out_valid), 0);
    check("reset_prediction", int'(bus.prediction), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) idle();
    check("idle_out_valid", int'(bus.out_valid), 0);

    // Isolated samples
    send(3'd5, 3'd2, 1'b0);  // h=(1,0)
    repeat (4) idle();
    send(3'd1, 3'd6, 1'b1);  // h=(0,1)
    repeat (4) idle();
    send(3'd4, 3'd4, 1'b0);  // h=(1,1) tie -> 0
    repeat (4) idle();
    send(3'd0, 3'd0, 1'b0);  // h=(1,0)
    repeat (4) idle();

    // Back-to-back, plus threshold boundaries
    send(3'd5, 3'd2, 1'b0);
    send(3'd1, 3'd6, 1'b1);
    send(3'd4, 3'd4, 1'b0);
    send(3'd2, 3'd4, 1'b1);  // acc0=-2, acc1=4 at threshold
    send(3'd3, 3'd3, 1'b0);  // acc1=3 just under threshold
    send(3'd7, 3'd7, 1'b0);  // tie
    idle();
    send(3'd0, 3'd5, 1'b1);
    send(3'd3, 3'd4, 1'b1);  // acc0=-1
    repeat (5) idle();
    check("drained_before_reset", sb.size(), 0);

    // Mid-stream reset while a class-1 prediction is presented
    send(3'd1, 3'd6, 1'b1);
    send(3'd1, 3'd6, 1'b1);
    send(3'd1, 3'd6, 1'b1);
    idle();
    @(posedge clk);
    #2;
    check("pre_reset_out_valid", int'(bus.out_valid), 1);
    check("pre_reset_prediction", int'(bus.prediction), 1);
    rst_n = 1'b0;
    #1;
    check("async_reset_out_valid", int'(bus.out_valid), 0);
    check("async_reset_prediction", int'(bus.prediction), 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;

    // First sample after release must appear exactly 3 edges later
    send(3'd0, 3'd7, 1'b1);
    send(3'd6, 3'd1, 1'b0);
    repeat (6) idle();
    check("drained_at_end", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
